pe_array_ctrl: RTL and testbench

Sequencing controller on the driving side of the MAC PE array. It reads one weight and one activation vector per step from the weight and activation SRAMs and drives the array's activation, weight, enable, clear and shift inputs. After K steps it captures the array's scaled and clamped result vector and presents it on a valid/ready output.

---
 rtl/pe_array_ctrl_pkg.sv | 24 ++
 rtl/pe_array_ctrl_if.sv | 51 +++++
 rtl/pe_array_ctrl_delay.sv | 24 ++
 rtl/pe_array_ctrl.sv | 136 +++++++++++++
 tb/tb_pe_array_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pe_array_ctrl_pkg.sv
// Shared types and constants for the PE array sequencing controller.
package pe_pkg;

    localparam int PE_MAC_NUM = 10;
    localparam int PE_BW_ACT  = 8;
    localparam int PE_BW_WET  = 8;
    localparam int PE_AW      = 10;
    localparam int PE_LEN_W   = 10;

    // SRAM read latency plus the array's input register
    localparam int MAC_PIPE_DLY = 2;
    localparam int DRAIN_CYC    = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } pe_state_e;

    typedef logic [PE_MAC_NUM-1:0][PE_BW_ACT-1:0] pe_res_t;

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Signal bundle between pe_array_ctrl and its job source, SRAMs and PE array.
// Perf counter signals exist only when PE_ARRAY_CTRL_PERF_EN is defined.
interface pe_array_ctrl_if #(
    parameter int MAC_NUM = pe_pkg::PE_MAC_NUM,
    parameter int BW_ACT  = pe_pkg::PE_BW_ACT,
    parameter int AW      = pe_pkg::PE_AW,
    parameter int LEN_W   = pe_pkg::PE_LEN_W
);
    logic                            start;
    logic [LEN_W-1:0]                start_len;
    logic [AW-1:0]                   start_act_base;
    logic [AW-1:0]                   start_wet_base;
    logic [7:0]                      start_shift;
    logic                            busy;
    logic                            act_rd_en;
    logic [AW-1:0]                   act_rd_addr;
    logic                            wet_rd_en;
    logic [AW-1:0]                   wet_rd_addr;
    logic                            PE_mac_enable;
    logic                            PE_clear_acc;
    logic [7:0]                      PE_res_shift_num;
    logic [MAC_NUM-1:0][BW_ACT-1:0]  PE_result_out;
    logic                            res_valid;
    logic                            res_ready;
    logic [MAC_NUM-1:0][BW_ACT-1:0]  res_data;
`ifdef PE_ARRAY_CTRL_PERF_EN
    logic [31:0]                     perf_busy_cyc;
    logic [31:0]                     perf_stall_cyc;
`endif

    modport slave (
        input  start, start_len, start_act_base, start_wet_base, start_shift,
               res_ready, PE_result_out,
        output busy, act_rd_en, act_rd_addr, wet_rd_en, wet_rd_addr,
               PE_mac_enable, PE_clear_acc, PE_res_shift_num, res_valid, res_data
`ifdef PE_ARRAY_CTRL_PERF_EN
        , output perf_busy_cyc, perf_stall_cyc
`endif
    );

    modport master (
        output start, start_len, start_act_base, start_wet_base, start_shift,
               res_ready, PE_result_out,
        input  busy, act_rd_en, act_rd_addr, wet_rd_en, wet_rd_addr,
               PE_mac_enable, PE_clear_acc, PE_res_shift_num, res_valid, res_data
`ifdef PE_ARRAY_CTRL_PERF_EN
        , input perf_busy_cyc, perf_stall_cyc
`endif
    );

endinterface

// File: rtl/pe_array_ctrl_delay.sv
// N-stage single-bit delay line, used to align the SRAM read strobe with the
// array's accumulate enable.
module pe_ctrl_delay #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [N-1:0] vld_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= d_i;
            for (int i = 1; i < N; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign q_o = vld_pipe[N-1];

endmodule

// File: rtl/pe_array_ctrl.sv
// Sequences clear/feed/drain of the MAC PE array and hands the result out on valid/ready.
// Define PE_ARRAY_CTRL_PERF_EN to add saturating busy/stall cycle counters.
module pe_array_ctrl
    import pe_pkg::*;
#(
    parameter int MAC_NUM = PE_MAC_NUM,
    parameter int BW_ACT  = PE_BW_ACT,
    parameter int AW      = PE_AW,
    parameter int LEN_W   = PE_LEN_W
) (
    input  logic           clk,
    input  logic           reset,
    pe_array_ctrl_if.slave bus
);
    localparam int DCW = $clog2(DRAIN_CYC);

    pe_state_e                      state_q, state_d;
    logic [LEN_W-1:0]               len_q, len_d;
    logic [LEN_W-1:0]               step_q, step_d;
    logic [AW-1:0]                  act_addr_q, act_addr_d;
    logic [AW-1:0]                  wet_addr_q, wet_addr_d;
    logic [7:0]                     shift_q, shift_d;
    logic [DCW-1:0]                 drain_q, drain_d;
    logic [MAC_NUM-1:0][BW_ACT-1:0] res_q, res_d;
    logic                           feed_stb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            step_q     <= '0;
            act_addr_q <= '0;
            wet_addr_q <= '0;
            shift_q    <= '0;
            drain_q    <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            step_q     <= step_d;
            act_addr_q <= act_addr_d;
            wet_addr_q <= wet_addr_d;
            shift_q    <= shift_d;
            drain_q    <= drain_d;
            res_q      <= res_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        step_d     = step_q;
        act_addr_d = act_addr_q;
        wet_addr_d = wet_addr_q;
        shift_d    = shift_q;
        drain_d    = drain_q;
        res_d      = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = CLEAR;
                    len_d      = bus.start_len;
                    act_addr_d = bus.start_act_base;
                    wet_addr_d = bus.start_wet_base;
                    shift_d    = bus.start_shift;
                end
            end
            CLEAR: begin
                step_d  = '0;
                drain_d = '0;
                state_d = (len_q != '0) ? FEED : DRAIN;
            end
            FEED: begin
                // addresses wrap naturally at 2^AW
                step_d     = step_q + LEN_W'(1);
                act_addr_d = act_addr_q + AW'(1);
                wet_addr_d = wet_addr_q + AW'(1);
                if (step_q == len_q - LEN_W'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                drain_d = drain_q + DCW'(1);
                if (drain_q == DCW'(DRAIN_CYC - 1)) begin
                    res_d   = bus.PE_result_out;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        feed_stb             = (state_q == FEED);
        bus.busy             = (state_q != IDLE);
        bus.act_rd_en        = feed_stb;
        bus.wet_rd_en        = feed_stb;
        bus.act_rd_addr      = feed_stb ? act_addr_q : '0;
        bus.wet_rd_addr      = feed_stb ? wet_addr_q : '0;
        bus.PE_clear_acc     = (state_q == CLEAR);
        bus.PE_res_shift_num = shift_q;
        bus.res_valid        = (state_q == DONE);
        bus.res_data         = res_q;
    end

    pe_ctrl_delay #(
        .N(MAC_PIPE_DLY)
    ) u_en_dly (
        .clk  (clk),
        .reset(reset),
        .d_i  (feed_stb),
        .q_o  (bus.PE_mac_enable)
    );

`ifdef PE_ARRAY_CTRL_PERF_EN
    logic [31:0] busy_cyc_q, stall_cyc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cyc_q  <= '0;
            stall_cyc_q <= '0;
        end else begin
            if (state_q != IDLE && busy_cyc_q != '1) busy_cyc_q <= busy_cyc_q + 32'd1;
            if (state_q == DONE && !bus.res_ready && stall_cyc_q != '1)
                stall_cyc_q <= stall_cyc_q + 32'd1;
        end
    end

    assign bus.perf_busy_cyc  = busy_cyc_q;
    assign bus.perf_stall_cyc = stall_cyc_q;
`else
    // no performance counters in this build
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl with SRAM and MAC array behavioural models.
module tb_pe_array_ctrl;
    import pe_pkg::*;

    localparam int MAC_NUM = PE_MAC_NUM;
    localparam int BW_ACT  = PE_BW_ACT;
    localparam int AW      = PE_AW;
    localparam int LEN_W   = PE_LEN_W;
    localparam int RW      = MAC_NUM * BW_ACT;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pe_array_ctrl_if #(.MAC_NUM(MAC_NUM), .BW_ACT(BW_ACT), .AW(AW), .LEN_W(LEN_W)) bus ();

    pe_array_ctrl #(.MAC_NUM(MAC_NUM), .BW_ACT(BW_ACT), .AW(AW), .LEN_W(LEN_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // SRAMs (1-cycle read) feeding an array that registers its inputs once
    logic signed [7:0]  act_mem [0:1023];
    logic signed [7:0]  wet_mem [0:1023];
    logic signed [7:0]  act_dout = '0, wet_dout = '0, act_reg = '0, wet_reg = '0;
    logic signed [31:0] acc = '0, sh;
    logic [7:0]         lane;

    always @(posedge clk) begin
        if (bus.act_rd_en) act_dout <= act_mem[bus.act_rd_addr];
        if (bus.wet_rd_en) wet_dout <= wet_mem[bus.wet_rd_addr];
        act_reg <= act_dout;
        wet_reg <= wet_dout;
        if (bus.PE_clear_acc) acc <= '0;
        else if (bus.PE_mac_enable) acc <= acc + act_reg * wet_reg;
    end

    always_comb begin
        sh = acc >>> bus.PE_res_shift_num;
        if (sh > 127) lane = 8'h7f;
        else if (sh < -128) lane = 8'h80;
        else lane = sh[7:0];
        for (int l = 0; l < MAC_NUM; l++) bus.PE_result_out[l] = lane;
    end

    int n_chk = 0, n_err = 0;
    logic [63:0] en_m, clr_m, rd_m, wr_m;
    int first_v;
    logic [AW-1:0] addr_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] rep(input logic [7:0] v);
        return {MAC_NUM{v}};
    endfunction

    task automatic load(input int ab, input int wb, input int k, input int a, input int w);
        for (int i = 0; i < k; i++) begin
            act_mem[AW'(ab + i)] = 8'(a);
            wet_mem[AW'(wb + i)] = 8'(w);
        end
    endtask

    // cycle 0 = start cycle; records strobes per cycle until res_valid (bounded)
    task automatic run_job(input int k, input int ab, input int wb, input int s);
        en_m = '0; clr_m = '0; rd_m = '0; wr_m = '0; first_v = -1;
        addr_q.delete();
        bus.start_len      = LEN_W'(k);
        bus.start_act_base = AW'(ab);
        bus.start_wet_base = AW'(wb);
        bus.start_shift    = 8'(s);
        bus.start          = 1'b1;
        for (int c = 0; c < 80 && first_v < 0; c++) begin
            if (c > 0) begin
                tick();
                bus.start = 1'b0;
            end
            if (c < 64) begin
                en_m[c]  = bus.PE_mac_enable;
                clr_m[c] = bus.PE_clear_acc;
                rd_m[c]  = bus.act_rd_en;
                wr_m[c]  = bus.wet_rd_en;
            end
            if (bus.act_rd_en) addr_q.push_back(bus.act_rd_addr);
            if (bus.res_valid) first_v = c;
        end
        bus.start = 1'b0;
    endtask

    task automatic accept(input string tag);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk(tag, bus.busy, 1'b0);
    endtask

    initial begin
        logic [39:0] apack;
        logic        ok;
        reset = 1'b1;
        bus.start = 1'b0; bus.start_len = '0; bus.start_act_base = '0;
        bus.start_wet_base = '0; bus.start_shift = '0; bus.res_ready = 1'b0;
        for (int a = 0; a < 1024; a++) begin
            act_mem[a] = '0;
            wet_mem[a] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_valid", bus.res_valid, 1'b0);
        chk("rst_strobes", {bus.act_rd_en, bus.wet_rd_en, bus.PE_mac_enable, bus.PE_clear_acc}, 4'b0);
        chk("rst_data", bus.res_data, '0);
        chk("rst_shift", bus.PE_res_shift_num, 8'd0);
        reset = 1'b0;
        tick();

        // dot product K=4, 2*3
        load(0, 16, 4, 2, 3);
        run_job(4, 0, 16, 0);
        chk("t1_en", en_m, 64'h00f0);
        chk("t1_clr", clr_m, 64'h0002);
        chk("t1_rd", rd_m, 64'h003c);
        chk("t1_wrd", wr_m, 64'h003c);
        chk("t1_first_v", first_v, 10);
        chk("t1_data", bus.res_data, rep(8'd24));
        accept("t1_idle");

        // saturation
        load(32, 48, 4, 127, 127);
        run_job(4, 32, 48, 0);
        chk("t2_sat_hi", bus.res_data, rep(8'h7f));
        accept("t2_idle_a");
        run_job(4, 32, 48, 10);
        chk("t2_shift_num", bus.PE_res_shift_num, 8'd10);
        chk("t2_shift10", bus.res_data, rep(8'h3f));
        accept("t2_idle_b");
        load(64, 80, 1, -128, 127);
        run_job(1, 64, 80, 0);
        chk("t2_first_v_k1", first_v, 7);
        chk("t2_sat_lo", bus.res_data, rep(8'h80));
        accept("t2_idle_c");

        // activation address wrap
        load(1022, 5, 4, 5, -2);
        run_job(4, 1022, 5, 0);
        chk("t3_nrd", addr_q.size(), 4);
        apack = '0;
        foreach (addr_q[i]) apack = {apack[29:0], addr_q[i]};
        chk("t3_addr", apack, {10'd1022, 10'd1023, 10'd0, 10'd1});
        chk("t3_data", bus.res_data, rep(8'hd8));
        accept("t3_idle");

        // backpressure with a stray start
        load(100, 110, 2, 3, 4);
        run_job(2, 100, 110, 0);
        chk("t4_first_v", first_v, 8);
        bus.start_shift = 8'd5;
        bus.start_len   = LEN_W'(1);
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.start = (c == 2);
            tick();
            if (!(bus.res_valid && bus.res_data == rep(8'd24))) ok = 1'b0;
        end
        bus.start = 1'b0;
        chk("t4_hold", ok, 1'b1);
        chk("t4_busy", bus.busy, 1'b1);
        chk("t4_shift_kept", bus.PE_res_shift_num, 8'd0);
        bus.start = 1'b1;
        accept("t4_idle");
        bus.start = 1'b0;
        tick();
        chk("t4_start_ign", bus.busy, 1'b0);

        // zero-length job
        run_job(0, 0, 0, 0);
        chk("t5_clr", clr_m, 64'h0002);
        chk("t5_rd", rd_m | wr_m, 64'h0);
        chk("t5_en", en_m, 64'h0);
        chk("t5_first_v", first_v, 6);
        chk("t5_data", bus.res_data, '0);
        accept("t5_idle");

        // reset during FEED, then a clean job
        load(200, 300, 8, 7, 7);
        bus.start_len = LEN_W'(8); bus.start_act_base = AW'(200);
        bus.start_wet_base = AW'(300); bus.start_shift = 8'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        chk("t6_pre_en", {bus.act_rd_en, bus.PE_mac_enable}, 2'b11);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_busy", bus.busy, 1'b0);
        chk("t6_rst_strobes", {bus.act_rd_en, bus.wet_rd_en, bus.PE_mac_enable, bus.PE_clear_acc, bus.res_valid}, 5'b0);
        chk("t6_rst_addr", {bus.act_rd_addr, bus.wet_rd_addr}, 20'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        load(400, 500, 4, 1, 1);
        run_job(4, 400, 500, 0);
        chk("t6_first_v", first_v, 10);
        chk("t6_data", bus.res_data, rep(8'd4));
        accept("t6_idle");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
